// File: rtl/gt_streak_if.sv
// Valid/ready stream carrying the per-sample "a greater than b" comparator result.
interface gt_streak_if;
    logic in_valid;
    logic in_ready;
    logic gt;

    modport master (output in_valid, output gt, input in_ready);
    modport slave  (input in_valid, input gt, output in_ready);
endinterface

// File: rtl/gt_streak_detector.sv
// Counts consecutive gt=1 samples, pulses hit at THRESH, then back-pressures for HOLD_CYC cycles.
// Define GT_STREAK_TALLY_EN to add the saturating hit_tally output.
//
// state | meaning
// IDLE  | no streak in progress, streak=0
// RUN   | streak of 1..THRESH-1 gt samples in progress
// HOLD  | cooldown after a hit, in_ready low, streak held at THRESH
module gt_streak_detector #(
    parameter  int THRESH   = 3,
    parameter  int HOLD_CYC = 2,
    parameter  int TALLY_W  = 8,
    localparam int CNT_W    = $clog2(THRESH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    gt_streak_if.slave       bus,
    output logic [CNT_W-1:0] streak,
    output logic             hit,
    output logic             busy
`ifdef GT_STREAK_TALLY_EN
    ,
    output logic [TALLY_W-1:0] hit_tally
`endif
);

    localparam int CD_W = $clog2(HOLD_CYC + 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] streak_q, streak_d;
    logic             hit_q, hit_d;
    logic [CD_W-1:0]  cool_q, cool_d;
    logic             accept;

    assign bus.in_ready = (state_q != HOLD);
    assign busy         = (state_q == HOLD);
    assign streak       = streak_q;
    assign hit          = hit_q;
    assign accept       = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        streak_d = streak_q;
        cool_d   = cool_q;
        hit_d    = 1'b0;
        if (clear) begin
            state_d  = IDLE;
            streak_d = '0;
            cool_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && bus.gt) begin
                        streak_d = CNT_W'(1);
                        if (THRESH == 1) begin
                            state_d = HOLD;
                            cool_d  = CD_W'(HOLD_CYC);
                            hit_d   = 1'b1;
                        end else begin
                            state_d = RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (!bus.gt) begin
                            state_d  = IDLE;
                            streak_d = '0;
                        end else if (streak_q == CNT_W'(THRESH - 1)) begin
                            state_d  = HOLD;
                            streak_d = CNT_W'(THRESH);
                            cool_d   = CD_W'(HOLD_CYC);
                            hit_d    = 1'b1;
                        end else begin
                            streak_d = streak_q + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // Leaving on the edge that reads 1 makes HOLD last exactly HOLD_CYC cycles.
                    if (cool_q <= CD_W'(1)) begin
                        state_d  = IDLE;
                        streak_d = '0;
                        cool_d   = '0;
                    end else begin
                        cool_d = cool_q - CD_W'(1);
                    end
                end
                default: begin
                    state_d  = IDLE;
                    streak_d = '0;
                    cool_d   = '0;
                end
            endcase
        end
    end

`ifdef GT_STREAK_TALLY_EN
    logic [TALLY_W-1:0] tally_q, tally_d;

    assign hit_tally = tally_q;

    always_comb begin
        tally_d = tally_q;
        if (clear)
            tally_d = '0;
        else if (hit_q && (tally_q != {TALLY_W{1'b1}}))
            tally_d = tally_q + TALLY_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tally_q <= '0;
        else
            tally_q <= tally_d;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            streak_q <= '0;
            hit_q    <= 1'b0;
            cool_q   <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            hit_q    <= hit_d;
            cool_q   <= cool_d;
        end
    end

endmodule

// File: tb/tb_gt_streak_detector.sv
// Scoreboard bench: dut_a uses THRESH=3/HOLD_CYC=2, dut_b uses THRESH=1/HOLD_CYC=1, same stimulus.
module tb_gt_streak_detector;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_s = 1'b0;
    logic valid_s = 1'b0;
    logic gt_s = 1'b0;

    logic [1:0] streak_a;
    logic       hit_a, busy_a;
    logic       streak_b;
    logic       hit_b, busy_b;
`ifdef GT_STREAK_TALLY_EN
    logic [7:0] tally_a, tally_b;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int hit_times[$];

    gt_streak_if bus_a ();
    gt_streak_if bus_b ();

    assign bus_a.in_valid = valid_s;
    assign bus_a.gt       = gt_s;
    assign bus_b.in_valid = valid_s;
    assign bus_b.gt       = gt_s;

    gt_streak_detector #(.THRESH(3), .HOLD_CYC(2), .TALLY_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear_s), .bus(bus_a),
        .streak(streak_a), .hit(hit_a), .busy(busy_a)
`ifdef GT_STREAK_TALLY_EN
        , .hit_tally(tally_a)
`endif
    );

    gt_streak_detector #(.THRESH(1), .HOLD_CYC(1), .TALLY_W(8)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear_s), .bus(bus_b),
        .streak(streak_b), .hit(hit_b), .busy(busy_b)
`ifdef GT_STREAK_TALLY_EN
        , .hit_tally(tally_b)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int s_a; int h_a; int b_a; int t_a;
        int s_b; int h_b; int b_b; int t_b;
    } exp_t;

    exp_t sb[$];

    // Reference model state, one set per instance.
    int ma_s = 0, ma_left = 0, ma_h = 0, ma_t = 0;
    int mb_s = 0, mb_left = 0, mb_h = 0, mb_t = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_step(input int thr, input int hold, input bit v, input bit g, input bit c,
                              inout int s, inout int left, inout int h, inout int t);
        if (c) begin
            s = 0; left = 0; h = 0; t = 0;
        end else begin
            if (h != 0 && t < 255) t = t + 1;
            h = 0;
            if (left > 0) begin
                left = left - 1;
                if (left == 0) s = 0;
            end else if (v) begin
                if (g) begin
                    s = s + 1;
                    if (s == thr) begin
                        left = hold;
                        h = 1;
                    end
                end else begin
                    s = 0;
                end
            end
        end
    endtask

    task automatic model_reset();
        ma_s = 0; ma_left = 0; ma_h = 0; ma_t = 0;
        mb_s = 0; mb_left = 0; mb_h = 0; mb_t = 0;
    endtask

    task automatic step(input bit v, input bit g, input bit c);
        exp_t e, o;
        valid_s = v;
        gt_s    = g;
        clear_s = c;
        model_step(3, 2, v, g, c, ma_s, ma_left, ma_h, ma_t);
        model_step(1, 1, v, g, c, mb_s, mb_left, mb_h, mb_t);
        e.s_a = ma_s; e.h_a = ma_h; e.b_a = (ma_left > 0) ? 1 : 0; e.t_a = ma_t;
        e.s_b = mb_s; e.h_b = mb_h; e.b_b = (mb_left > 0) ? 1 : 0; e.t_b = mb_t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        o = sb.pop_front();
        chk("a_streak", int'(streak_a), o.s_a);
        chk("a_hit", int'(hit_a), o.h_a);
        chk("a_busy", int'(busy_a), o.b_a);
        chk("a_ready", int'(bus_a.in_ready), 1 - o.b_a);
        chk("b_streak", int'(streak_b), o.s_b);
        chk("b_hit", int'(hit_b), o.h_b);
        chk("b_busy", int'(busy_b), o.b_b);
        chk("b_ready", int'(bus_b.in_ready), 1 - o.b_b);
`ifdef GT_STREAK_TALLY_EN
        chk("a_tally", int'(tally_a), o.t_a);
        chk("b_tally", int'(tally_b), o.t_b);
`endif
        if (hit_a) hit_times.push_back(cyc);
        clear_s = 1'b0;
    endtask

    initial begin
        #3;
        chk("rst_streak", int'(streak_a), 0);
        chk("rst_hit", int'(hit_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_ready", int'(bus_a.in_ready), 1);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // back-to-back 1,1,1 then drain the cooldown
        repeat (3) step(1, 1, 0);
        repeat (4) step(0, 0, 0);

        // 1,1,0,1 never reaches the threshold
        step(1, 1, 0); step(1, 1, 0); step(1, 0, 0); step(1, 1, 0);
        step(1, 0, 0);
        step(0, 0, 0);

        // idle gaps inside a streak
        repeat (3) begin
            step(1, 1, 0);
            repeat (3) step(0, 0, 0);
        end
        repeat (2) step(0, 0, 0);

        // continuous gt=1 across two hits
        hit_times.delete();
        repeat (12) step(1, 1, 0);
        if (hit_times.size() >= 2)
            chk("hit_spacing", hit_times[1] - hit_times[0], 5);
        else
            chk("hit_count", hit_times.size(), 2);
        repeat (3) step(0, 0, 0);
        step(1, 0, 0);

        // asynchronous reset in the middle of a streak
        step(1, 1, 0); step(1, 1, 0);
        chk("pre_rst_streak", int'(streak_a), 2);
        valid_s = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_streak", int'(streak_a), 0);
        chk("async_ready", int'(bus_a.in_ready), 1);
        chk("async_hit", int'(hit_a), 0);
        chk("async_busy_b", int'(busy_b), 0);
        model_reset();
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // clear beats a simultaneous accepted gt=1
        step(1, 1, 0); step(1, 1, 0);
        step(1, 1, 1);
        chk("clear_streak", int'(streak_a), 0);
        repeat (2) step(0, 0, 0);

        // clear aborting HOLD
        repeat (3) step(1, 1, 0);
        step(1, 1, 1);
        step(0, 0, 0);

        // random traffic with occasional clear
        for (int i = 0; i < 300; i++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));

        // long run so the tally saturates
        step(0, 0, 1);
        repeat (600) step(1, 1, 0);
`ifdef GT_STREAK_TALLY_EN
        chk("b_tally_sat", int'(tally_b), 255);
`endif
        chk("sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

endmodule
